// File: rtl/sec_div_pkg.sv
// Shared encodings for the constant-time iterative divider.
package sec_div_pkg;

   typedef enum logic [1:0] {
      STATE_IDLE = 2'd0,
      STATE_CALC = 2'd1,
      STATE_DONE = 2'd2
   } state_t;

   localparam logic DOMAIN_PUB = 1'b0;
   localparam logic DOMAIN_SEC = 1'b1;

endpackage

// File: rtl/sec_div_step.sv
// One combinational restoring-division step; carries the domain of its operands.
module sec_div_step #(
   parameter int p_nbits = 32
) (
   input  logic [p_nbits:0]   rem_i,
   input  logic [p_nbits-1:0] quot_i,
   input  logic [p_nbits-1:0] divisor_i,
   output logic [p_nbits:0]   rem_o,
   output logic [p_nbits-1:0] quot_o
);

   logic [p_nbits+1:0] shifted;
   logic [p_nbits+1:0] trial;
   logic               trial_neg;

   // One extra guard bit above the shifted remainder makes the MSB a clean sign.
   assign shifted = {rem_i, quot_i[p_nbits-1]};

   vc_Subtractor #(.p_nbits(p_nbits + 2)) u_trial_sub (
      .in0_i  (shifted),
      .in1_i  ({2'b00, divisor_i}),
      .diff_o (trial)
   );

   assign trial_neg = trial[p_nbits+1];
   assign rem_o     = trial_neg ? shifted[p_nbits:0] : trial[p_nbits:0];
   assign quot_o    = {quot_i[p_nbits-2:0], ~trial_neg};

endmodule

// File: rtl/vc_subtractor.sv
// Plain unsigned subtractor; all bits of both operands are labelled with the same domain.
module vc_Subtractor #(
   parameter int p_nbits = 32
) (
   input  logic [p_nbits-1:0] in0_i,
   input  logic [p_nbits-1:0] in1_i,
   output logic [p_nbits-1:0] diff_o
);

   assign diff_o = in0_i - in1_i;

endmodule

// File: rtl/sec_iter_divider.sv
// Fixed-latency iterative unsigned divider with domain-tagged operands and
// scrubbing of all data registers once a response has been consumed.
module sec_iter_divider
   import sec_div_pkg::*;
#(
   parameter int p_nbits     = 32,
   parameter int p_cnt_nbits = $clog2(p_nbits)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               req_val,
   output logic               req_rdy,
   input  logic               req_domain,
   input  logic [p_nbits-1:0] req_a,
   input  logic [p_nbits-1:0] req_b,
   output logic               resp_val,
   input  logic               resp_rdy,
   output logic               resp_domain,
   output logic [p_nbits-1:0] resp_quot,
   output logic [p_nbits-1:0] resp_rem
);

   state_t                 state_q, state_d;
   logic [p_cnt_nbits-1:0] cnt_q, cnt_d;
   logic [p_nbits:0]       rem_q, rem_d;
   logic [p_nbits-1:0]     quot_q, quot_d;
   logic [p_nbits-1:0]     div_q, div_d;
   logic                   dom_q, dom_d;
   logic [p_nbits-1:0]     out_quot_q, out_quot_d;
   logic [p_nbits-1:0]     out_rem_q, out_rem_d;
   logic                   out_dom_q, out_dom_d;

   logic [p_nbits:0]       step_rem;
   logic [p_nbits-1:0]     step_quot;

   sec_div_step #(.p_nbits(p_nbits)) u_step (
      .rem_i     (rem_q),
      .quot_i    (quot_q),
      .divisor_i (div_q),
      .rem_o     (step_rem),
      .quot_o    (step_quot)
   );

   // NOTE: every signal written here is defaulted first so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      quot_d     = quot_q;
      div_d      = div_q;
      dom_d      = dom_q;
      out_quot_d = out_quot_q;
      out_rem_d  = out_rem_q;
      out_dom_d  = out_dom_q;
      req_rdy    = 1'b0;
      resp_val   = 1'b0;

      case (state_q)
         STATE_IDLE: begin
            req_rdy = 1'b1;
            if (req_val) begin
               state_d = STATE_CALC;
               dom_d   = req_domain;
               quot_d  = req_a;
               div_d   = req_b;
               rem_d   = '0;
               cnt_d   = p_cnt_nbits'(p_nbits - 1);
            end
         end
         STATE_CALC: begin
            rem_d  = step_rem;
            quot_d = step_quot;
            // Only the counter steers the FSM; operand values never shorten the run.
            if (cnt_q == '0) begin
               state_d    = STATE_DONE;
               out_quot_d = step_quot;
               out_rem_d  = step_rem[p_nbits-1:0];
               out_dom_d  = dom_q;
            end else begin
               cnt_d = cnt_q - p_cnt_nbits'(1);
            end
         end
         STATE_DONE: begin
            resp_val = 1'b1;
            if (resp_rdy) begin
               state_d    = STATE_IDLE;
               rem_d      = '0;
               quot_d     = '0;
               div_d      = '0;
               dom_d      = DOMAIN_PUB;
               out_quot_d = '0;
               out_rem_d  = '0;
               out_dom_d  = DOMAIN_PUB;
            end
         end
         default: state_d = STATE_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= STATE_IDLE;
         cnt_q      <= '0;
         rem_q      <= '0;
         quot_q     <= '0;
         div_q      <= '0;
         dom_q      <= DOMAIN_PUB;
         out_quot_q <= '0;
         out_rem_q  <= '0;
         out_dom_q  <= DOMAIN_PUB;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         quot_q     <= quot_d;
         div_q      <= div_d;
         dom_q      <= dom_d;
         out_quot_q <= out_quot_d;
         out_rem_q  <= out_rem_d;
         out_dom_q  <= out_dom_d;
      end
   end

   assign resp_quot   = out_quot_q;
   assign resp_rem    = out_rem_q;
   assign resp_domain = out_dom_q;

endmodule

// File: tb/tb_sec_iter_divider.sv
// Scoreboard bench for sec_iter_divider: results, fixed latency, backpressure,
// post-handshake scrubbing, mid-operation reset and back-to-back throughput.
module tb_sec_iter_divider;

   localparam int P   = 32;
   localparam int LAT = P + 1;

   typedef struct {
      logic [P-1:0] quot;
      logic [P-1:0] rem;
      logic         dom;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         req_val, req_rdy, req_domain;
   logic [P-1:0] req_a, req_b;
   logic         resp_val, resp_rdy, resp_domain;
   logic [P-1:0] resp_quot, resp_rem;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   sec_iter_divider #(.p_nbits(P)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_val     (req_val),
      .req_rdy     (req_rdy),
      .req_domain  (req_domain),
      .req_a       (req_a),
      .req_b       (req_b),
      .resp_val    (resp_val),
      .resp_rdy    (resp_rdy),
      .resp_domain (resp_domain),
      .resp_quot   (resp_quot),
      .resp_rem    (resp_rem)
   );

   function automatic exp_t model(input logic [P-1:0] a, input logic [P-1:0] b, input logic d);
      exp_t e;
      e.dom = d;
      if (b == '0) begin
         e.quot = '1;
         e.rem  = a;
      end else begin
         e.quot = a / b;
         e.rem  = a % b;
      end
      return e;
   endfunction

   // Presents one request in IDLE; returns after the accept edge.
   task automatic drive_req(input logic [P-1:0] a, input logic [P-1:0] b, input logic d);
      @(negedge clk);
      req_val    = 1'b1;
      req_a      = a;
      req_b      = b;
      req_domain = d;
      sb.push_back(model(a, b, d));
      @(posedge clk);
      #1 req_val = 1'b0;
   endtask

   // lat = index of the edge (after the accept edge) at which the response can first be taken.
   task automatic wait_resp(output int lat, output bit timed_out);
      lat       = 0;
      timed_out = 1'b1;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (resp_val) begin
            lat       = i;
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #1;
      checks++;
      if ({req_rdy, resp_val, resp_domain, resp_quot, resp_rem} !== {1'b1, 1'b0, 1'b0, {2*P{1'b0}}}) begin
         errors++;
         $display("FAIL reset_state got rdy=%b val=%b dom=%b q=%h r=%h want rdy=1 val=0 dom=0 q=0 r=0",
                  req_rdy, resp_val, resp_domain, resp_quot, resp_rem);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({req_rdy, resp_val} !== 2'b10) begin
         errors++;
         $display("FAIL idle_after_reset got rdy=%b val=%b want rdy=1 val=0", req_rdy, resp_val);
      end
   endtask

   task automatic test_divide();
      logic [P-1:0] ta[8];
      logic [P-1:0] tb[8];
      int  lat;
      bit  to;
      exp_t e;
      ta = '{32'd100, 32'd1, 32'hFFFF_FFFF, 32'd0,         32'd5, 32'd0, 32'd0, 32'd0};
      tb = '{32'd7,   32'd1, 32'd3,         32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
      for (int i = 4; i < 8; i++) begin
         ta[i] = $urandom;
         tb[i] = $urandom_range(1, 65535);
      end
      for (int i = 0; i < 8; i++) begin
         drive_req(ta[i], tb[i], 1'b0);
         wait_resp(lat, to);
         checks++;
         if (to || lat != LAT) begin
            errors++;
            $display("FAIL latency[%0d] got %0d (timeout=%0b) want %0d", i, lat, to, LAT);
         end
         e = sb.pop_front();
         checks++;
         if ({resp_domain, resp_quot, resp_rem} !== {e.dom, e.quot, e.rem}) begin
            errors++;
            $display("FAIL divide[%0d] %h/%h got dom=%b q=%h r=%h want dom=%b q=%h r=%h",
                     i, ta[i], tb[i], resp_domain, resp_quot, resp_rem, e.dom, e.quot, e.rem);
         end
         resp_rdy = 1'b1;
         @(posedge clk);
         #1 resp_rdy = 1'b0;
         checks++;
         if ({resp_val, req_rdy, resp_domain, resp_quot, resp_rem} !== {1'b0, 1'b1, 1'b0, {2*P{1'b0}}}) begin
            errors++;
            $display("FAIL post_handshake[%0d] got val=%b rdy=%b dom=%b q=%h r=%h want 0,1,0,0,0",
                     i, resp_val, req_rdy, resp_domain, resp_quot, resp_rem);
         end
      end
   endtask

   task automatic test_backpressure();
      int  lat;
      bit  to;
      int  bad = 0;
      exp_t e;
      drive_req(32'd1000, 32'd10, 1'b0);
      wait_resp(lat, to);
      e = sb.pop_front();
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         if ({resp_val, req_rdy, resp_domain, resp_quot, resp_rem} !== {1'b1, 1'b0, e.dom, e.quot, e.rem})
            bad++;
      end
      checks++;
      if (to || bad != 0) begin
         errors++;
         $display("FAIL backpressure_hold got %0d unstable cycles (timeout=%0b) q=%h r=%h want 0 with q=%h r=%h",
                  bad, to, resp_quot, resp_rem, e.quot, e.rem);
      end
      resp_rdy = 1'b1;
      @(posedge clk);
      #1 resp_rdy = 1'b0;
      checks++;
      if ({resp_val, req_rdy} !== 2'b01) begin
         errors++;
         $display("FAIL backpressure_release got val=%b rdy=%b want val=0 rdy=1", resp_val, req_rdy);
      end
   endtask

   task automatic test_domain_scrub();
      int  lat;
      bit  to;
      exp_t e;
      drive_req(32'hDEAD_BEEF, 32'h10, 1'b1);
      wait_resp(lat, to);
      e = sb.pop_front();
      checks++;
      if (to || {resp_domain, resp_quot, resp_rem} !== {e.dom, e.quot, e.rem}) begin
         errors++;
         $display("FAIL secret_result got dom=%b q=%h r=%h (timeout=%0b) want dom=%b q=%h r=%h",
                  resp_domain, resp_quot, resp_rem, to, e.dom, e.quot, e.rem);
      end
      resp_rdy = 1'b1;
      @(posedge clk);
      #1 resp_rdy = 1'b0;
      @(negedge clk);
      checks++;
      if ({req_rdy, resp_domain, resp_quot, resp_rem} !== {1'b1, 1'b0, {2*P{1'b0}}}) begin
         errors++;
         $display("FAIL scrub_idle got rdy=%b dom=%b q=%h r=%h want rdy=1 dom=0 q=0 r=0",
                  req_rdy, resp_domain, resp_quot, resp_rem);
      end
      drive_req(32'd9, 32'd4, 1'b0);
      wait_resp(lat, to);
      e = sb.pop_front();
      checks++;
      if (to || {resp_domain, resp_quot, resp_rem} !== {e.dom, e.quot, e.rem}) begin
         errors++;
         $display("FAIL public_after_secret got dom=%b q=%h r=%h (timeout=%0b) want dom=%b q=%h r=%h",
                  resp_domain, resp_quot, resp_rem, to, e.dom, e.quot, e.rem);
      end
      resp_rdy = 1'b1;
      @(posedge clk);
      #1 resp_rdy = 1'b0;
   endtask

   task automatic test_reset_mid_op();
      int  lat;
      bit  to;
      int  spurious = 0;
      exp_t e;
      drive_req(32'd12345, 32'd67, 1'b1);
      repeat (10) @(negedge clk);
      checks++;
      if ({req_rdy, resp_val, resp_domain, resp_quot, resp_rem} !== {1'b0, 1'b0, 1'b0, {2*P{1'b0}}}) begin
         errors++;
         $display("FAIL calc_outputs_hidden got rdy=%b val=%b dom=%b q=%h r=%h want 0,0,0,0,0",
                  req_rdy, resp_val, resp_domain, resp_quot, resp_rem);
      end
      reset_n = 1'b0;
      void'(sb.pop_back());
      #1;
      checks++;
      if ({req_rdy, resp_val, resp_domain, resp_quot, resp_rem} !== {1'b1, 1'b0, 1'b0, {2*P{1'b0}}}) begin
         errors++;
         $display("FAIL abort_reset got rdy=%b val=%b dom=%b q=%h r=%h want 1,0,0,0,0",
                  req_rdy, resp_val, resp_domain, resp_quot, resp_rem);
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (resp_val) spurious++;
      end
      checks++;
      if (spurious != 0) begin
         errors++;
         $display("FAIL no_resp_after_abort got %0d valid cycles want 0", spurious);
      end
      drive_req(32'd77, 32'd8, 1'b0);
      wait_resp(lat, to);
      e = sb.pop_front();
      checks++;
      if (to || lat != LAT || {resp_domain, resp_quot, resp_rem} !== {e.dom, e.quot, e.rem}) begin
         errors++;
         $display("FAIL op_after_abort got lat=%0d q=%h r=%h (timeout=%0b) want lat=%0d q=%h r=%h",
                  lat, resp_quot, resp_rem, to, LAT, e.quot, e.rem);
      end
      resp_rdy = 1'b1;
      @(posedge clk);
      #1 resp_rdy = 1'b0;
   endtask

   task automatic test_back_to_back();
      int  k = -1;
      int  lat;
      bit  to;
      bit  seen = 1'b0;
      exp_t e;
      resp_rdy = 1'b1;
      drive_req(32'd50000, 32'd123, 1'b1);
      // Hold the second request pending so its accept edge marks the operation period.
      req_val    = 1'b1;
      req_a      = 32'd4096;
      req_b      = 32'd3;
      req_domain = 1'b0;
      sb.push_back(model(32'd4096, 32'd3, 1'b0));
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (resp_val && !seen) begin
            seen = 1'b1;
            e = sb.pop_front();
            checks++;
            if ({resp_domain, resp_quot, resp_rem} !== {e.dom, e.quot, e.rem}) begin
               errors++;
               $display("FAIL b2b_first got dom=%b q=%h r=%h want dom=%b q=%h r=%h",
                        resp_domain, resp_quot, resp_rem, e.dom, e.quot, e.rem);
            end
         end
         if (req_rdy) begin
            k = i;
            break;
         end
      end
      @(posedge clk);
      #1 req_val = 1'b0;
      checks++;
      if (!seen || k + 1 != P + 2) begin
         errors++;
         $display("FAIL b2b_period got %0d cycles (first_seen=%0b) want %0d", k + 1, seen, P + 2);
      end
      wait_resp(lat, to);
      e = sb.pop_front();
      checks++;
      if (to || lat != LAT || {resp_domain, resp_quot, resp_rem} !== {e.dom, e.quot, e.rem}) begin
         errors++;
         $display("FAIL b2b_second got lat=%0d q=%h r=%h (timeout=%0b) want lat=%0d q=%h r=%h",
                  lat, resp_quot, resp_rem, to, LAT, e.quot, e.rem);
      end
      @(posedge clk);
      #1 resp_rdy = 1'b0;
   endtask

   initial begin
      req_val    = 1'b0;
      req_domain = 1'b0;
      req_a      = '0;
      req_b      = '0;
      resp_rdy   = 1'b0;
      test_reset();
      test_divide();
      test_backpressure();
      test_domain_scrub();
      test_reset_mid_op();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
